addsub_arbiter: RTL and testbench



---
 rtl/addsub_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_addsub_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Shares one n-bit add/subtract datapath between two requesters. Each
// requester presents an operation with a valid/ready handshake. A round-robin
// arbiter accepts one request at a time. The block then computes the
// sum/difference and returns it on a response port, together with carry-out,
// signed overflow and the ID of the requester that issued it.
//
// Operation sequence: IDLE (grant + latch operands) -> EXEC (compute and
// register the result) -> RESP (hold until the consumer takes it) -> IDLE.
//
// Ports
//   clk           : single clock, rising edge
//   reset         : asynchronous, active-high reset
//   req0_valid    : requester 0 has an operation pending
//   req0_ready    : requester 0 accepted this cycle (combinational, IDLE only)
//   req0_x/y      : operands of requester 0
//   req0_sub      : 0 = x+y, 1 = x-y
//   req1_*        : same set of signals for requester 1
//   rsp_valid     : result held and valid
//   rsp_ready     : consumer takes the result
//   rsp_id        : requester that issued the result
//   rsp_s         : result
//   rsp_c_out     : carry out of the MSB (for subtraction, 1 = no borrow)
//   rsp_overflow  : two's-complement overflow
//   busy          : an operation is in flight (state is not IDLE)
//   op_count      : number of completed responses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module addsub_arbiter #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [n-1:0] req0_x,
   input  logic [n-1:0] req0_y,
   input  logic         req0_sub,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [n-1:0] req1_x,
   input  logic [n-1:0] req1_y,
   input  logic         req1_sub,

   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [n-1:0] rsp_s,
   output logic         rsp_c_out,
   output logic         rsp_overflow,

   output logic         busy,
   output logic [7:0]   op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_reg;

   // Priority pointer: requester that wins when both are valid.
   logic         ptr_reg;

   // Operand registers loaded on the grant edge.
   logic [n-1:0] op_x_reg;
   logic [n-1:0] op_y_reg;
   logic         op_sub_reg;
   logic         op_id_reg;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic         any_valid;
   logic         grant_id;
   logic         accept;

   always_comb begin
      any_valid = req0_valid | req1_valid;
      // With both valid the pointer decides. Otherwise the single valid
      // requester wins. When neither is valid the value is unused.
      if (req0_valid && req1_valid)
         grant_id = ptr_reg;
      else
         grant_id = ~req0_valid;
   end

   // Readies are gated by reset. The state register is already IDLE while
   // reset is held, so without the gate a valid input would leak a ready.
   assign accept     = (state_reg == IDLE) && any_valid && !reset;
   assign req0_ready = accept && !grant_id;
   assign req1_ready = accept &&  grant_id;

   // Operand selection for the granted requester.
   logic [n-1:0] sel_x;
   logic [n-1:0] sel_y;
   logic         sel_sub;

   always_comb begin
      if (grant_id) begin
         sel_x   = req1_x;
         sel_y   = req1_y;
         sel_sub = req1_sub;
      end else begin
         sel_x   = req0_x;
         sel_y   = req0_y;
         sel_sub = req0_sub;
      end
   end

   // ---------------------------------------------------------------------
   // Add/subtract datapath: s = x + (y ^ {n{sub}}) + sub.
   // The datapath is built as an explicit ripple chain. This keeps the carry
   // into the MSB available for the overflow term.
   // ---------------------------------------------------------------------
   logic [n-1:0] y_eff;
   logic [n-1:0] sum;
   logic [n:0]   carry;

   assign carry[0] = op_sub_reg;

   generate
      for (genvar gi = 0; gi < n; gi++) begin : g_ripple
         assign y_eff[gi]   = op_y_reg[gi] ^ op_sub_reg;
         assign sum[gi]     = op_x_reg[gi] ^ y_eff[gi] ^ carry[gi];
         assign carry[gi+1] = (op_x_reg[gi] & y_eff[gi]) |
                              (op_x_reg[gi] & carry[gi]) |
                              (y_eff[gi]    & carry[gi]);
      end
   endgenerate

   logic dp_c_out;
   logic dp_overflow;

   assign dp_c_out    = carry[n];
   assign dp_overflow = carry[n] ^ carry[n-1];

   // ---------------------------------------------------------------------
   // Control FSM with registered response outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         ptr_reg      <= 1'b0;
         op_x_reg     <= '0;
         op_y_reg     <= '0;
         op_sub_reg   <= 1'b0;
         op_id_reg    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_s        <= '0;
         rsp_c_out    <= 1'b0;
         rsp_overflow <= 1'b0;
         op_count     <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_valid) begin
                  op_x_reg   <= sel_x;
                  op_y_reg   <= sel_y;
                  op_sub_reg <= sel_sub;
                  op_id_reg  <= grant_id;
                  state_reg  <= EXEC;
               end
            end

            EXEC: begin
               rsp_s        <= sum;
               rsp_c_out    <= dp_c_out;
               rsp_overflow <= dp_overflow;
               rsp_id       <= op_id_reg;
               rsp_valid    <= 1'b1;
               state_reg    <= RESP;
            end

            RESP: begin
               // The rsp_* data fields are left untouched here. They keep the
               // last result after rsp_valid drops.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
                  // Hand priority to the other requester on completion. This
                  // happens even when the served requester was alone.
                  ptr_reg   <= ~op_id_reg;
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

   logic       clk;
   logic       reset;
   logic       req0_valid, req0_ready, req0_sub;
   logic [3:0] req0_x, req0_y;
   logic       req1_valid, req1_ready, req1_sub;
   logic [3:0] req1_x, req1_y;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_c_out, rsp_overflow;
   logic [3:0] rsp_s;
   logic       busy;
   logic [7:0] op_count;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;

   addsub_arbiter #(.n(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_x       (req0_x),
      .req0_y       (req0_y),
      .req0_sub     (req0_sub),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_x       (req1_x),
      .req1_y       (req1_y),
      .req1_sub     (req1_sub),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_s        (rsp_s),
      .rsp_c_out    (rsp_c_out),
      .rsp_overflow (rsp_overflow),
      .busy         (busy),
      .op_count     (op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic [3:0] x,
                          input logic [3:0] y, input logic sub);
      if (k == 0) begin
         req0_valid = v; req0_x = x; req0_y = y; req0_sub = sub;
      end else begin
         req1_valid = v; req1_x = x; req1_y = y; req1_sub = sub;
      end
   endtask

   // Runs one transaction from the current IDLE cycle to completion.
   // hold > 0 keeps rsp_ready low for that many extra cycles in RESP.
   task automatic serve(input int exp_id, input logic [3:0] es, input logic ec,
                        input logic eov, input int hold);
      int waited;
      rsp_ready = (hold == 0);
      #1;
      waited = 0;
      while (!(req0_ready || req1_ready) && waited < 10) begin
         @(posedge clk); #2;
         waited++;
      end
      if (!(req0_ready || req1_ready)) begin
         check("grant_timeout", 32'd0, 32'd1);
         return;
      end
      check("grant", 32'({req1_ready, req0_ready}), (exp_id == 1) ? 32'd2 : 32'd1);
      @(posedge clk); #2;
      check("exec_busy", 32'(busy), 32'd1);
      check("exec_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #2;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_s", 32'(rsp_s), 32'(es));
      check("rsp_c_out", 32'(rsp_c_out), 32'(ec));
      check("rsp_overflow", 32'(rsp_overflow), 32'(eov));
      check("rsp_id", 32'(rsp_id), 32'(exp_id));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #2;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_s", 32'(rsp_s), 32'(es));
         check("hold_c_out", 32'(rsp_c_out), 32'(ec));
         check("hold_overflow", 32'(rsp_overflow), 32'(eov));
         check("hold_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      exp_count = (exp_count + 1) % 256;
      check("done_valid", 32'(rsp_valid), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      check("op_count", 32'(op_count), 32'(exp_count));
      $display("txn id=%0d s=%0d c=%0d ov=%0d op_count=%0d", rsp_id, rsp_s,
               rsp_c_out, rsp_overflow, op_count);
   endtask

   initial begin
      reset = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 1'b1, 4'd0, 4'd0, 1'b0);
      set_req(1, 1'b1, 4'd0, 4'd0, 1'b0);

      // Reset state, including readies held low despite valid requests
      repeat (2) @(posedge clk);
      #2;
      check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_s", 32'(rsp_s), 32'd0);
      check("rst_c_out", 32'(rsp_c_out), 32'd0);
      check("rst_overflow", 32'(rsp_overflow), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
      reset = 1'b0;
      @(posedge clk); #2;

      // Directed arithmetic, one requester at a time
      set_req(0, 1'b1, 4'd3, 4'd5, 1'b0);          // 3+5 = 8, signed overflow
      serve(0, 4'd8, 1'b0, 1'b1, 0);
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
      set_req(1, 1'b1, 4'd5, 4'd3, 1'b1);          // 5-3 = 2, no borrow
      serve(1, 4'd2, 1'b1, 1'b0, 0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
      set_req(0, 1'b1, 4'd3, 4'd5, 1'b1);          // 3-5 = 14, borrow
      serve(0, 4'd14, 1'b0, 1'b0, 0);
      set_req(0, 1'b1, 4'd8, 4'd1, 1'b1);          // -8-1 = 7, overflow
      serve(0, 4'd7, 1'b1, 1'b1, 0);

      // Backpressure: pointer now favors requester 1. Requester 0 stays
      // valid and must not see a ready while the response is held.
      set_req(0, 1'b1, 4'd2, 4'd3, 1'b0);
      set_req(1, 1'b1, 4'd15, 4'd1, 1'b0);         // 15+1 = 0, carry
      serve(1, 4'd0, 1'b1, 1'b0, 5);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
      serve(0, 4'd5, 1'b0, 1'b0, 0);               // granted right after completion

      // Reset in EXEC while the pointer favors requester 1
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
      set_req(1, 1'b1, 4'd1, 4'd1, 1'b0);
      #1;
      check("pre_rst_grant", 32'(req1_ready), 32'd1);
      @(posedge clk); #2;
      check("pre_rst_busy", 32'(busy), 32'd1);
      set_req(0, 1'b1, 4'd1, 4'd1, 1'b0);          // 1+1 = 2
      set_req(1, 1'b1, 4'd7, 4'd1, 1'b0);          // 7+1 = 8, overflow
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_op_count", 32'(op_count), 32'd0);
      check("mid_rst_s", 32'(rsp_s), 32'd0);
      check("mid_rst_id", 32'(rsp_id), 32'd0);
      @(posedge clk); #2;
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      exp_count = 0;

      // Round-robin with both requesters held valid continuously
      serve(0, 4'd2, 1'b0, 1'b0, 0);
      serve(1, 4'd8, 1'b0, 1'b1, 0);
      serve(0, 4'd2, 1'b0, 1'b0, 0);
      serve(1, 4'd8, 1'b0, 1'b1, 0);
      check("rr_op_count", 32'(op_count), 32'd4);

      // Counter wrap: 256 back-to-back operations from requester 0
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
      set_req(0, 1'b1, 4'd1, 4'd2, 1'b0);          // 1+2 = 3
      for (int i = 0; i < 256; i++) begin
         serve(0, 4'd3, 1'b0, 1'b0, 0);
      end
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
      @(posedge clk); #2;
      check("wrap_op_count", 32'(op_count), 32'd4);
      check("wrap_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
